// File: rtl/tdm_demux4.sv
// tdm_demux4: rebuilds four parallel channels from a TDM word stream (slot 0..3, SOF-flagged).
// Optional completed-frame counter output enabled by defining TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sof,
    output logic [4*WIDTH-1:0]   out_data,
    output logic                 out_valid,
    output logic                 locked,
`ifdef TDM_DEMUX_FRAME_CNT_EN
    output logic [15:0]          frame_cnt,
`endif
    output logic                 frame_err
);

    localparam int unsigned OUT_W = 4 * WIDTH;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [1:0]         slot, slot_n;
    logic [WIDTH-1:0]   shadow0, shadow0_n;
    logic [WIDTH-1:0]   shadow1, shadow1_n;
    logic [WIDTH-1:0]   shadow2, shadow2_n;
    logic [OUT_W-1:0]   out_data_n;
    logic               out_valid_n;
    logic               frame_err_n;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [15:0]        frame_cnt_n;
`endif

    // State, shadow and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            slot      <= 2'd0;
            shadow0   <= '0;
            shadow1   <= '0;
            shadow2   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
            frame_cnt <= 16'd0;
`endif
        end else begin
            state     <= state_n;
            slot      <= slot_n;
            shadow0   <= shadow0_n;
            shadow1   <= shadow1_n;
            shadow2   <= shadow2_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            locked    <= (state_n == LOCK);
            frame_err <= frame_err_n;
`ifdef TDM_DEMUX_FRAME_CNT_EN
            frame_cnt <= frame_cnt_n;
`endif
        end
    end

    // Next-state and framing decisions; idle cycles leave everything untouched
    always_comb begin
        state_n     = state;
        slot_n      = slot;
        shadow0_n   = shadow0;
        shadow1_n   = shadow1;
        shadow2_n   = shadow2;
        out_data_n  = out_data;
        out_valid_n = 1'b0;
        frame_err_n = 1'b0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
        frame_cnt_n = frame_cnt;
`endif
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_sof) begin
                        shadow0_n = in_data;
                        slot_n    = 2'd1;
                        state_n   = LOCK;
                    end
                end
                LOCK: begin
                    if (in_sof) begin
                        // An SOF anywhere but slot 0 aborts the partial frame and restarts it
                        frame_err_n = (slot != 2'd0);
                        shadow0_n   = in_data;
                        slot_n      = 2'd1;
                    end else begin
                        case (slot)
                            2'd0: begin
                                frame_err_n = 1'b1;
                                state_n     = HUNT;
                                slot_n      = 2'd0;
                            end
                            2'd1: begin
                                shadow1_n = in_data;
                                slot_n    = 2'd2;
                            end
                            2'd2: begin
                                shadow2_n = in_data;
                                slot_n    = 2'd3;
                            end
                            default: begin
                                out_data_n  = OUT_W'({in_data, shadow2, shadow1, shadow0});
                                out_valid_n = 1'b1;
                                slot_n      = 2'd0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
                                frame_cnt_n = frame_cnt + 16'd1;
`endif
                            end
                        endcase
                    end
                end
                default: begin
                    state_n = HUNT;
                    slot_n  = 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed stimulus with a scoreboard queue of expected frames and framing errors.
module tb_tdm_demux4;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned OUT_W = 4 * WIDTH;

    typedef struct {
        bit               is_err;
        logic [OUT_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_sof;
    logic [OUT_W-1:0]   out_data;
    logic               out_valid;
    logic               locked;
    logic               frame_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [15:0]        frame_cnt;
`endif

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   frames_done = 0;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .out_data  (out_data),
        .out_valid (out_valid),
        .locked    (locked),
`ifdef TDM_DEMUX_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One input cycle; returns 1ns after the sampling edge
    task automatic drive(input logic v, input logic sof, input logic [WIDTH-1:0] d);
        in_valid = v;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 8'hEE);
    endtask

    task automatic push_frame(input logic [OUT_W-1:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        exp_q.push_back(e);
        frames_done++;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    // Sends a full clean frame with an optional idle gap between beats
    task automatic send_frame(input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] b1,
                              input logic [WIDTH-1:0] b2, input logic [WIDTH-1:0] b3,
                              input int gap);
        drive(1'b1, 1'b1, b0);
        idle(gap);
        drive(1'b1, 1'b0, b1);
        idle(gap);
        drive(1'b1, 1'b0, b2);
        idle(gap);
        push_frame({b3, b2, b1, b0});
        drive(1'b1, 1'b0, b3);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    chk("unexpected_out_valid", {OUT_W{1'b1}}, '0);
                end else begin
                    chk("frame_data", out_data, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
            if (frame_err === 1'b1) begin
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    chk("unexpected_frame_err", 1, 0);
                end else begin
                    chk("frame_err", 1, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_data", out_data, '0);
        chk("reset_out_valid", OUT_W'(out_valid), '0);
        chk("reset_locked", OUT_W'(locked), '0);
        chk("reset_frame_err", OUT_W'(frame_err), '0);

        // Back-to-back frame
        drive(1'b1, 1'b1, 8'h11);
        chk("locked_after_sof", OUT_W'(locked), OUT_W'(1));
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b0, 8'h33);
        push_frame(32'h44332211);
        drive(1'b1, 1'b0, 8'h44);
        chk("out_valid_latency", OUT_W'(out_valid), OUT_W'(1));
        chk("frame1_data", out_data, 32'h44332211);
        idle(1);
        chk("out_valid_single_pulse", OUT_W'(out_valid), '0);

        // Gapped frame with distinct contents, then the spec frame with gaps
        send_frame(8'hD0, 8'hD1, 8'hD2, 8'hD3, 3);
        drive(1'b1, 1'b1, 8'h11);
        idle(3);
        chk("gap_hold", out_data, 32'hD3D2D1D0);
        chk("gap_no_valid", OUT_W'(out_valid), '0);
        drive(1'b1, 1'b0, 8'h22);
        idle(3);
        drive(1'b1, 1'b0, 8'h33);
        idle(3);
        push_frame(32'h44332211);
        drive(1'b1, 1'b0, 8'h44);
        idle(2);
        chk("gap_frame_data", out_data, 32'h44332211);

        // Early SOF
        drive(1'b1, 1'b1, 8'hA0);
        drive(1'b1, 1'b0, 8'hA1);
        push_err();
        drive(1'b1, 1'b1, 8'hB0);
        chk("early_sof_locked", OUT_W'(locked), OUT_W'(1));
        chk("early_sof_hold", out_data, 32'h44332211);
        drive(1'b1, 1'b0, 8'hB1);
        drive(1'b1, 1'b0, 8'hB2);
        push_frame(32'hB3B2B1B0);
        drive(1'b1, 1'b0, 8'hB3);
        chk("early_sof_frame", out_data, 32'hB3B2B1B0);

        // Missing SOF drops to HUNT; non-SOF beats ignored until relock
        push_err();
        drive(1'b1, 1'b0, 8'h55);
        chk("missing_sof_unlock", OUT_W'(locked), '0);
        drive(1'b1, 1'b0, 8'h66);
        drive(1'b1, 1'b0, 8'h77);
        chk("hunt_hold", out_data, 32'hB3B2B1B0);
        chk("hunt_still_unlocked", OUT_W'(locked), '0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 0);
        chk("relock", OUT_W'(locked), OUT_W'(1));
        chk("relock_frame", out_data, 32'h04030201);

        // Two back-to-back frames: out_valid every 4th cycle
        send_frame(8'h31, 8'h32, 8'h33, 8'h34, 0);
        send_frame(8'h41, 8'h42, 8'h43, 8'h44, 0);
        chk("b2b_frame", out_data, 32'h44434241);

        // Reset mid-frame, colliding with a valid beat
        drive(1'b1, 1'b1, 8'h10);
        drive(1'b1, 1'b0, 8'h20);
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h30);
        rst = 1'b0;
        chk("midreset_out_data", out_data, '0);
        chk("midreset_locked", OUT_W'(locked), '0);
        drive(1'b1, 1'b0, 8'h40);
        drive(1'b1, 1'b0, 8'h50);
        chk("midreset_ignored", OUT_W'(locked), '0);
        chk("midreset_hold_zero", out_data, '0);
        frames_done = 0;
        send_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1);
        chk("post_reset_frame", out_data, 32'hC4C3C2C1);
`ifdef TDM_DEMUX_FRAME_CNT_EN
        send_frame(8'hE1, 8'hE2, 8'hE3, 8'hE4, 0);
        send_frame(8'hF1, 8'hF2, 8'hF3, 8'hF4, 0);
        chk("frame_cnt", OUT_W'(frame_cnt), OUT_W'(3));
`endif

        idle(3);
        chk("scoreboard_drained", OUT_W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
